// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C master controller (and, later, the
// slave). Holds the controller FSM state encoding, the ACK/NACK and R/W bit
// encodings on the wire, and the default data-array depth.
package i2c_pkg;

    // Default depth of the wr_data/rd_data byte arrays.
    localparam int DEFAULT_MAX_BYTES = 10;

    // Bit values as they appear on SDA.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_RD   = 1'b1;
    localparam logic I2C_WR   = 1'b0;

    // Controller FSM state encoding. Plain constants so that legacy code
    // can compare raw 4-bit vectors; the enum gives the same values a type.
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_START = 4'd1;
    localparam logic [3:0] ST_ADDR  = 4'd2;
    localparam logic [3:0] ST_A_ACK = 4'd3;
    localparam logic [3:0] ST_WDATA = 4'd4;
    localparam logic [3:0] ST_W_ACK = 4'd5;
    localparam logic [3:0] ST_RDATA = 4'd6;
    localparam logic [3:0] ST_R_ACK = 4'd7;
    localparam logic [3:0] ST_STOP  = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_ADDR  = ST_ADDR,
        S_A_ACK = ST_A_ACK,
        S_WDATA = ST_WDATA,
        S_W_ACK = ST_W_ACK,
        S_RDATA = ST_RDATA,
        S_R_ACK = ST_R_ACK,
        S_STOP  = ST_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: divides clk by CLK_DIV to produce SCL quarter periods.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   clear       - synchronous clear (held while the controller is idle)
//   q_tick      - high on the last cycle of each quarter
//   q_first     - high on the first cycle of each quarter
//   q_idx       - current quarter within the bit slot (0..3)
module i2c_quarter_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    output logic       q_tick,
    output logic       q_first,
    output logic [1:0] q_idx
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    assign q_tick  = (cnt_q == LAST);
    assign q_first = (cnt_q == '0);
    assign q_idx   = idx_q;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (q_tick) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;   // wraps Q3 -> Q0 at the slot boundary
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C controller. Runs one complete bus
// transaction (START, address + R/W, N data bytes, STOP) per host command.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   start       - command strobe, only looked at while busy=0
//   addr, rw, num_bytes - command fields, captured with an accepted start
//   wr_data     - write payload, byte 0 first, held stable while busy
//   busy        - transaction in progress
//   done        - one-cycle pulse when a transaction finishes
//   nack        - an address/write ACK slot sampled high
//   xfer_count  - data bytes completed in the current/last transaction
//   rd_data     - received bytes, byte k = k-th byte read
//   scl         - push-pull bus clock, idles high
//   sda         - open-drain data line, only ever pulled low
//
// Host handshake: a command is accepted in any cycle where start=1 and
// busy=0; busy rises the next cycle and stays high until the cycle in which
// done pulses. done and busy=0 coincide, so a new start may be accepted in
// the done cycle. start while busy is dropped, not queued.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = DEFAULT_MAX_BYTES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [6:0]                addr,
    input  logic                      rw,
    input  logic [3:0]                num_bytes,
    input  logic [MAX_BYTES-1:0][7:0] wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      nack,
    output logic [3:0]                xfer_count,
    output logic [MAX_BYTES-1:0][7:0] rd_data,
    output logic                      scl,
    inout  wire                       sda
);

    localparam logic [3:0] MAX_NUM = 4'(MAX_BYTES);

    logic [3:0]  state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [3:0]  num_q, num_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  xfer_q, xfer_d;
    logic        nack_q, nack_d;
    logic        done_q, done_d;
    logic        samp_q;
    logic [MAX_BYTES-1:0][7:0] rd_q;

    logic        q_tick, q_first;
    logic [1:0]  q_idx;
    logic        slot_end, sample_now;
    logic [7:0]  addr_byte, cur_byte;
    logic        more_rd;
    logic        sda_oe;

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_IDLE),
        .q_tick  (q_tick),
        .q_first (q_first),
        .q_idx   (q_idx)
    );

    assign slot_end   = q_tick && (q_idx == 2'd3);
    assign sample_now = q_first && (q_idx == 2'd3);
    assign addr_byte  = {addr_q, rw_q};
    // Another byte follows the one currently being acknowledged.
    assign more_rd    = (xfer_q + 4'd1) < num_q;

    always_comb begin
        cur_byte = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (xfer_q == 4'(k)) cur_byte = wr_data[k];
        end
    end

    // Bus drive decoded from registered state and quarter index. Data bits
    // only change at Q0; START and STOP deliberately move SDA while SCL is
    // high to form the bus conditions.
    always_comb begin
        sda_oe = 1'b0;
        scl    = q_idx[1];
        case (state_q)
            ST_IDLE:  scl    = 1'b1;
            ST_START: begin
                scl    = 1'b1;
                sda_oe = q_idx[1];
            end
            ST_ADDR:  sda_oe = ~addr_byte[3'd7 - bit_q];
            ST_WDATA: sda_oe = ~cur_byte[3'd7 - bit_q];
            ST_R_ACK: sda_oe = more_rd;         // pull low = I2C_ACK
            ST_STOP:  sda_oe = (q_idx != 2'd3);
            default:  sda_oe = 1'b0;
        endcase
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        num_d   = num_q;
        bit_d   = bit_q;
        xfer_d  = xfer_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    addr_d  = addr;
                    rw_d    = rw;
                    num_d   = (num_bytes > MAX_NUM) ? MAX_NUM : num_bytes;
                    bit_d   = 3'd0;
                    xfer_d  = 4'd0;
                    nack_d  = 1'b0;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_d = ST_ADDR;
                    bit_d   = 3'd0;
                end
            end
            ST_ADDR: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;       // wraps to 0 for the next byte
                    if (bit_q == 3'd7) state_d = ST_A_ACK;
                end
            end
            ST_A_ACK: begin
                if (slot_end) begin
                    if (samp_q == I2C_NACK) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (num_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else if (rw_q == I2C_WR) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_W_ACK;
                end
            end
            ST_W_ACK: begin
                if (slot_end) begin
                    xfer_d = xfer_q + 4'd1;
                    if (samp_q == I2C_NACK) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if ((xfer_q + 4'd1) == num_q) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_R_ACK;
                end
            end
            ST_R_ACK: begin
                if (slot_end) begin
                    xfer_d  = xfer_q + 4'd1;
                    state_d = more_rd ? ST_RDATA : ST_STOP;
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            num_q   <= '0;
            bit_q   <= '0;
            xfer_q  <= '0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            samp_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            num_q   <= num_d;
            bit_q   <= bit_d;
            xfer_q  <= xfer_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            if (sample_now) samp_q <= sda;
        end
    end

    // Received bits shift in MSB first; bytes not addressed this transaction
    // keep whatever they held before.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else if ((state_q == ST_RDATA) && sample_now) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
                if (xfer_q == 4'(k)) rd_q[k] <= {rd_q[k][6:0], sda};
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign nack       = nack_q;
    assign xfer_count = xfer_q;
    assign rd_data    = rd_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl with a behavioural I2C slave at address 54.
module tb_i2c_master_ctrl;

    localparam int D  = 4;          // CLK_DIV
    localparam int MB = 10;         // MAX_BYTES
    localparam int Q  = 4 * D;      // cycles per bit slot
    localparam logic [6:0] MY_ADDR = 7'd54;
    localparam int EW = 38;         // {chk_rd, nack, cnt[4], rd0[8], rd1[8], lat[16]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, start, rw;
    logic [6:0]           addr;
    logic [3:0]           num_bytes;
    logic [MB-1:0][7:0]   wr_data;
    logic                 busy, done, nack, scl;
    logic [3:0]           xfer_count;
    logic [MB-1:0][7:0]   rd_data;
    wire                  sda;

    i2c_master_ctrl #(.CLK_DIV(D), .MAX_BYTES(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .addr       (addr),
        .rw         (rw),
        .num_bytes  (num_bytes),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .nack       (nack),
        .xfer_count (xfer_count),
        .rd_data    (rd_data),
        .scl        (scl),
        .sda        (sda)
    );

    pullup (sda);

    // ---------------- behavioural slave ----------------
    logic       sl_oe = 1'b0;
    logic       sl_scl_d = 1'b1, sl_sda_d = 1'b1;
    int         sl_phase = 0, sl_bits = 0, sl_idx = 0, sl_stops = 0;
    logic [7:0] sl_shift = 8'h00, sl_tx = 8'h00;
    logic       sl_rw = 1'b0, sl_more = 1'b0;
    logic [7:0] sl_rx [16];
    logic [7:0] sl_mem [16];

    assign sda = sl_oe ? 1'b0 : 1'bz;

    always @(posedge clk) begin
        sl_scl_d <= scl;
        sl_sda_d <= sda;
        if (sl_scl_d && scl && sl_sda_d && !sda) begin          // START
            sl_phase <= 1; sl_bits <= 0; sl_idx <= 0; sl_oe <= 1'b0;
        end else if (sl_scl_d && scl && !sl_sda_d && sda) begin // STOP
            sl_phase <= 0; sl_oe <= 1'b0; sl_stops <= sl_stops + 1;
        end else if (!sl_scl_d && scl) begin                     // SCL rise
            case (sl_phase)
                1, 3: begin sl_shift <= {sl_shift[6:0], sda}; sl_bits <= sl_bits + 1; end
                5:    sl_bits <= sl_bits + 1;
                6:    sl_more <= (sda == 1'b0);
                default: ;
            endcase
        end else if (sl_scl_d && !scl) begin                     // SCL fall
            case (sl_phase)
                1: if (sl_bits == 8) begin
                    if (sl_shift[7:1] == MY_ADDR) begin
                        sl_oe <= 1'b1; sl_rw <= sl_shift[0]; sl_phase <= 2;
                    end else begin
                        sl_phase <= 0;
                    end
                end
                2: begin
                    sl_bits <= 0;
                    if (sl_rw) begin
                        sl_tx <= sl_mem[sl_idx]; sl_oe <= ~sl_mem[sl_idx][7]; sl_phase <= 5;
                    end else begin
                        sl_oe <= 1'b0; sl_phase <= 3;
                    end
                end
                3: if (sl_bits == 8) begin
                    sl_rx[sl_idx] <= sl_shift; sl_idx <= sl_idx + 1; sl_oe <= 1'b1; sl_phase <= 4;
                end
                4: begin sl_oe <= 1'b0; sl_bits <= 0; sl_phase <= 3; end
                5: if (sl_bits == 8) begin
                    sl_oe <= 1'b0; sl_phase <= 6;
                end else begin
                    sl_oe <= ~sl_tx[3'(7 - sl_bits)];
                end
                6: if (sl_more) begin
                    sl_idx <= sl_idx + 1; sl_tx <= sl_mem[sl_idx + 1];
                    sl_oe <= ~sl_mem[sl_idx + 1][7]; sl_bits <= 0; sl_phase <= 5;
                end else begin
                    sl_oe <= 1'b0; sl_phase <= 0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    logic [EW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          done_prev = 1'b0;
    logic [EW-1:0] e;
    int            lat;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_single_cycle", 32'(done_prev), 32'(0));
            chk("done_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                lat = cyc - start_cyc;
                chk("busy_low_at_done", 32'(busy), 32'(0));
                chk("nack", 32'(nack), 32'(e[36]));
                chk("xfer_count", 32'(xfer_count), 32'(e[35:32]));
                chk("done_latency", 32'(lat), 32'(e[15:0]));
                if (e[37]) begin
                    chk("rd_data0", 32'(rd_data[0]), 32'(e[31:24]));
                    chk("rd_data1", 32'(rd_data[1]), 32'(e[23:16]));
                end
            end
        end
        done_prev = done;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [6:0] a, input logic r, input logic [3:0] n,
                        input logic push, input logic enack, input logic [3:0] ecnt,
                        input logic chkrd, input logic [7:0] e0, input logic [7:0] e1,
                        input int slots);
        if (push) exp_q.push_back({chkrd, enack, ecnt, e0, e1, 16'(1 + Q * slots)});
        addr = a; rw = r; num_bytes = n; start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'(1));
        @(negedge clk);
    endtask

    task automatic check_slave_rx(input string nm, input int n);
        for (int i = 0; i < n; i++) chk({nm, "_slave_rx"}, 32'(sl_rx[i]), 32'(wr_data[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    int stops_before;

    initial begin
        reset = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; num_bytes = '0; wr_data = '0;
        for (int i = 0; i < 16; i++) begin sl_rx[i] = 8'h00; sl_mem[i] = 8'h00; end
        sl_mem[0] = 8'h3C;
        sl_mem[1] = 8'h81;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_nack", 32'(nack), 32'(0));
        chk("rst_xfer", 32'(xfer_count), 32'(0));
        chk("rst_rd_zero", 32'(rd_data == '0), 32'(1));
        chk("rst_scl", 32'(scl), 32'(1));
        chk("rst_sda", 32'(sda), 32'(1));
        reset = 1'b0;
        @(negedge clk);

        // Write 3 bytes: 10 + 27 + STOP = 38 slots.
        wr_data[0] = 8'hA5; wr_data[1] = 8'h5A; wr_data[2] = 8'hC3;
        send(7'd54, 1'b0, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 8'h00, 8'h00, 38);
        chk("wr3_busy", 32'(busy), 32'(1));
        wait_done("wr3");
        check_slave_rx("wr3", 3);

        // Read 2 bytes: 10 + 18 + STOP = 29 slots. Slot 18 is the first
        // R_ACK (master pulls low), slot 27 the last (released).
        send(7'd54, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b1, 8'h3C, 8'h81, 29);
        repeat (Q * 18 + 3 * D) @(negedge clk);
        chk("rd_first_rack_sda", 32'(sda), 32'(0));
        repeat (Q * 9) @(negedge clk);
        chk("rd_last_rack_sda", 32'(sda), 32'(1));
        wait_done("rd2");

        // Wrong address: 11 slots, nack, STOP on the bus, rd_data untouched.
        stops_before = sl_stops;
        send(7'd55, 1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 1'b1, 8'h3C, 8'h81, 11);
        wait_done("badaddr");
        chk("badaddr_stop_seen", 32'(sl_stops - stops_before), 32'(1));

        // Address probe: nack cleared by the new start, no data slots.
        stops_before = sl_stops;
        send(7'd54, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 11);
        wait_done("probe");
        chk("probe_stop_seen", 32'(sl_stops - stops_before), 32'(1));

        // num_bytes above MAX_BYTES clamps to 10 bytes: 11 + 90 slots.
        for (int i = 0; i < MB; i++) wr_data[i] = 8'(i * 17 + 3);
        send(7'd54, 1'b0, 4'd15, 1'b1, 1'b0, 4'd10, 1'b0, 8'h00, 8'h00, 101);
        wait_done("clamp");
        check_slave_rx("clamp", MB);

        // Start while busy is ignored.
        wr_data[0] = 8'h11; wr_data[1] = 8'h22;
        send(7'd54, 1'b0, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 8'h00, 8'h00, 29);
        repeat (48) @(negedge clk);
        addr = 7'd55; rw = 1'b1; num_bytes = 4'd5; start = 1'b1;
        chk("busy_reject_busy", 32'(busy), 32'(1));
        @(negedge clk);
        start = 1'b0;
        wait_done("busyrej");
        check_slave_rx("busyrej", 2);

        // Reset during the first data byte of a write: no done, bus idle.
        wr_data[0] = 8'hA5; wr_data[1] = 8'h5A; wr_data[2] = 8'hC3;
        send(7'd54, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 38);
        repeat (Q * 12 + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_scl", 32'(scl), 32'(1));
        chk("midrst_sda", 32'(sda), 32'(1));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_rd_zero", 32'(rd_data == '0), 32'(1));
        reset = 1'b0;
        repeat (700) @(negedge clk);

        // Fresh write after the reset.
        send(7'd54, 1'b0, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 8'h00, 8'h00, 38);
        wait_done("postrst");
        check_slave_rx("postrst", 3);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-master I2C controller that sequences complete bus transactions (START, 7-bit address + R/W, N data bytes with ACK/NACK, STOP) toward the `I2C_slave` population on a shared open-drain SDA line. It accepts one command at a time from a local host, generates SCL from the system clock, and reports completion, received data and NACK status. Bit encoding and the byte-array shape of the data ports match the slave's ports, so the two blocks connect back-to-back in system benches.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per SCL quarter-period; legal range ≥ 2; SCL period is 4·CLK_DIV cycles.
- `MAX_BYTES`, 10: depth of the data arrays; `num_bytes` is legal in the range 0..MAX_BYTES.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  command strobe; sampled only while `busy`=0.
- `addr`  in  7  target address; captured on an accepted `start`.
- `rw`  in  1  R/W bit: 1 = master reads (slave transmits), 0 = master writes; captured on an accepted `start`.
- `num_bytes`  in  4  data bytes to transfer; captured on an accepted `start`; values above MAX_BYTES are clamped to MAX_BYTES.
- `wr_data`  in  [MAX_BYTES-1:0][7:0]  write payload; byte 0 is sent first, MSB first; must be held stable while `busy`=1.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at the end of every transaction.
- `nack`  out  1  set if any ACK slot sampled high; cleared on an accepted `start`.
- `xfer_count`  out  4  number of data bytes completed in the current or last transaction.
- `rd_data`  out  [MAX_BYTES-1:0][7:0]  received bytes; byte k holds the k-th byte received.
- `scl`  out  1  bus clock; push-pull, idles at 1.
- `sda`  inout  1  open-drain: drives 0 when `sda_oe`=1, otherwise 'z.

## Operation
- **Reset:** all outputs take these values.
  - `busy`=0, `done`=0, `nack`=0, `xfer_count`=0, `rd_data`=0, `scl`=1, `sda` released.
  - FSM goes to IDLE and the quarter counter clears.
- **Command capture:** on `start`=1 with `busy`=0, the block latches `addr`, `rw` and the clamped `num_bytes`, clears `nack` and `xfer_count`, and sets `busy` on the next cycle.
- **`start` while busy:** ignored; no queueing.
- **Bit slots:** every bit is one slot of 4 quarters, Q0..Q3.
  - `scl`=0 in Q0–Q1 and `scl`=1 in Q2–Q3.
  - SDA changes only at the start of Q0.
  - SDA is sampled on the first cycle of Q3.
- **FSM states:** IDLE, START, ADDR, A_ACK, WDATA, W_ACK, RDATA, R_ACK, STOP.
- **IDLE → START** on an accepted `start`.
- **START slot:** `scl`=1 throughout; SDA is released in Q0–Q1 and pulled low in Q2–Q3.
- **ADDR:** 8 slots sending `addr[6]`..`addr[0]`, then `rw`. Then A_ACK.
- **A_ACK:** SDA released; the sampled value decides the next state.
  - Sample 1 → `nack`=1, go to STOP.
  - Else if `num_bytes`=0 → STOP (address probe).
  - Else if `rw`=0 → WDATA.
  - Else → RDATA.
- **WDATA:** 8 slots driving `wr_data[xfer_count]` MSB first, then W_ACK.
- **W_ACK:** SDA released; the sample is taken and `xfer_count` increments.
  - Sample 1 → `nack`=1, go to STOP.
  - Else if `xfer_count` = `num_bytes` → STOP.
  - Else → WDATA.
- **RDATA:** SDA released for 8 slots; the sampled bits shift into `rd_data[xfer_count]` MSB first. Then R_ACK.
- **R_ACK:** the master drives ACK (0) if more bytes remain, and NACK (released) on the last byte. `xfer_count` increments, then go to RDATA or STOP.
- **STOP slot:** SDA low in Q0–Q2 with `scl` low in Q0–Q1 and high from Q2; SDA is released in Q3 (SDA rises while SCL is high).
  - After Q3: `done` pulses, `busy` falls in the same cycle, and the FSM returns to IDLE.
- **Reset mid-transaction:** takes effect on the next edge.
  - Bus goes to `scl`=1 with SDA released; no STOP is generated.
  - `done` does not pulse.

## Timing
- Accepted `start` at cycle 0 → `busy`=1 at cycle 1 → START slot begins at cycle 1.
- Slot count is 10 + 9·n for an address ACK with n data bytes, plus the STOP slot, so 11 + 9·n slots total. Address NACK gives 11 slots.
- `done` is asserted at cycle 1 + 4·CLK_DIV·(slots).
- The earliest next `start` is accepted in the same cycle that `done` is high.
- `rd_data` and `xfer_count` are final when `done` is high. They hold until the next accepted `start`; `rd_data` bytes beyond `xfer_count` keep their previous contents.
- CLK_DIV ≥ 2 is required so the slave's one-cycle SCL/SDA edge detection sees every level for at least 2 cycles.

## Structure
- **`i2c_pkg`** holds:
  - the FSM state enum;
  - `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1;
  - `I2C_RD`=1'b1 and `I2C_WR`=1'b0;
  - the default `MAX_BYTES`=10. The slave will share this package later.
- **`i2c_quarter_timer`** is a sub-module: a divide-by-CLK_DIV counter with a 2-bit quarter index. It outputs a `q_tick` strobe and `q_idx`, and has a synchronous `clear` driven by IDLE.

## Test plan
- **Write 3 bytes:** `addr`=54, `rw`=0, `num_bytes`=3, `wr_data`={..,0xC3,0x5A,0xA5}, with slave MY_ADDR=54. Expect `nack`=0, `xfer_count`=3, and slave `data_out` receiving 0xA5,0x5A,0xC3. Expect `done` exactly 4·CLK_DIV·38+1 cycles after `start`.
- **Read 2 bytes:** `addr`=54, `rw`=1, `num_bytes`=2, slave `data_in[0]`=0x3C and `[1]`=0x81. Expect `rd_data[0]`=0x3C, `rd_data[1]`=0x81, `nack`=0, and the master's SDA released during the final R_ACK.
- **Wrong address:** `addr`=55 with the slave at 54. Expect A_ACK sampled 1, `nack`=1, `xfer_count`=0, a STOP on the bus, and `done` after 11 slots.
- **Address probe:** `num_bytes`=0 to address 54. Expect `nack`=0, `done` after 11 slots, and no data slots.
- **Reset and busy rejection:** a second `start` with different `addr` while `busy`=1 is ignored and the bus trace is unchanged. `reset` asserted during byte 1 of a write gives `scl`=1, `sda`='z, `busy`=0 and no `done` the following cycle. A fresh write to address 54 then completes normally.
